// File: rtl/debounce_pkg.sv
// Shared defaults and parameter validation for the multi-channel debouncer.
// Latency: n/a (constants and an elaboration-time check only).
// Backpressure: n/a.
package debounce_pkg;

    localparam int DB_CNT_W       = 16;
    localparam int DB_CNT_MAX     = 65535;
    localparam int DB_THRESH      = 64000;
    localparam int DB_SYNC_STAGES = 2;

    // The assert threshold must sit above mid-scale so the deassert point
    // (CNT_MAX-THRESH) is strictly below it and a real hysteresis band exists.
    // The counter must also fit in CNT_W bits and the synchroniser needs two flops.
    function automatic bit db_params_ok(input int cnt_w, input int cnt_max,
                                        input int thresh, input int sync_stages);
        longint unsigned span;
        span = longint'(1) << cnt_w;
        db_params_ok = (cnt_w >= 1) && (cnt_w <= 31) && (cnt_max > 0) &&
                       (longint'(cnt_max) < longint'(span)) &&
                       (thresh > cnt_max / 2) && (thresh <= cnt_max) &&
                       (sync_stages >= 2);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: synchroniser, saturating hysteresis counter, level and edge flops.
// Latency: level/pulse appear SYNC_STAGES+THRESH enabled edges after the first high sample.
// Backpressure: none; sample_en_i only gates filter updates, the synchroniser always runs.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CNT_W       = DB_CNT_W,
    parameter int CNT_MAX     = DB_CNT_MAX,
    parameter int THRESH      = DB_THRESH,
    parameter int SYNC_STAGES = DB_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sample_en_i,
    input  logic data_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(CNT_MAX - THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchroniser shifts every clock so metastability settles regardless of sample_en_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_i};
        end
    end

    // Next counter/level/edge values; level is judged on the new count so it moves on the same edge.
    always_comb begin
        cnt_d = cnt_q;
        if (sample_en_i) begin
            if (sync_s && (cnt_q != CNT_TOP)) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (!sync_s && (cnt_q != CNT_ZERO)) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end

        level_d = level_q;
        if (cnt_d >= CNT_HI) begin
            level_d = 1'b1;
        end else if (cnt_d <= CNT_LO) begin
            level_d = 1'b0;
        end

        // With sample_en_i low cnt_d==cnt_q, so the level holds and both pulses stay low.
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    // Filter state and registered outputs; reset yields no pulse because all flops clear together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// CHANNELS independent debounce lanes sharing one sample strobe, plus an any-edge summary.
// Latency: SYNC_STAGES+THRESH enabled edges from first high sample to level_out/rise_out.
// Backpressure: none; inputs are free-running pins, outputs are registered strobes.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = DB_CNT_W,
    parameter int CNT_MAX     = DB_CNT_MAX,
    parameter int THRESH      = DB_THRESH,
    parameter int SYNC_STAGES = DB_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] data_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_out,
    output logic [CHANNELS-1:0] fall_out,
    output logic                any_edge
);

    // Refuse to build with an empty or inverted hysteresis band.
    if (CHANNELS < 1 || !db_params_ok(CNT_W, CNT_MAX, THRESH, SYNC_STAGES)) begin : g_bad_params
        $error("debounce_multi: invalid CHANNELS/CNT_W/CNT_MAX/THRESH/SYNC_STAGES");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .CNT_W       (CNT_W),
            .CNT_MAX     (CNT_MAX),
            .THRESH      (THRESH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk_i       (clk),
            .rst_i       (rst),
            .sample_en_i (sample_en),
            .data_i      (data_in[i]),
            .level_o     (level_out[i]),
            .rise_o      (rise_out[i]),
            .fall_o      (fall_out[i])
        );
    end

    // Summary strobe built only from registered pulses, so it cannot glitch from data_in.
    assign any_edge = (|rise_out) | (|fall_out);

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-input debounce/edge block.
- Each channel:
  - synchronises a raw asynchronous input (buttons, USB-side strobes);
  - filters it with a saturating up/down counter using hysteresis;
  - emits a registered clean level plus one-cycle rise and fall pulses.
- A shared sample-enable lets one prescaler slow all channels.
- Sits between board pins and the USB/control logic.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- CNT_W, 16, counter width per channel.
- CNT_MAX, 65535, counter saturation value (must be < 2**CNT_W).
- THRESH, 64000, assert threshold. Deassert threshold is CNT_MAX-THRESH. Elaboration check: THRESH > CNT_MAX/2 and THRESH <= CNT_MAX.
- SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
- clk, input, 1, single clock.
- rst, input, 1, asynchronous active-high reset.
- sample_en, input, 1, counter update strobe. Tie to 1 for per-clock sampling.
- data_in, input, CHANNELS, raw asynchronous inputs.
- level_out, output, CHANNELS, debounced registered level.
- rise_out, output, CHANNELS, one-cycle pulse on level_out 0->1.
- fall_out, output, CHANNELS, one-cycle pulse on level_out 1->0.
- any_edge, output, 1, OR of all rise_out and fall_out bits.

Behaviour:
- Reset (async assert, sync release): all synchroniser flops, counters, level_out, rise_out, fall_out and any_edge are 0.
- Synchroniser:
  - SYNC_STAGES flops per channel, each loaded every clk regardless of sample_en.
  - s = last stage output.
- Counter, per channel, updated only when sample_en=1:
  - s=1 and cnt<CNT_MAX: cnt+1.
  - s=0 and cnt>0: cnt-1.
  - Otherwise hold; saturates at 0 and CNT_MAX, never wraps.
  - All arithmetic is CNT_W wide.
- Level register, computed from the next counter value cnt_n:
  - cnt_n >= THRESH: level 1.
  - cnt_n <= CNT_MAX-THRESH: level 0.
  - Otherwise hold.
  - level_out updates on the same edge the counter reaches a threshold. No combinational path from data_in to any output.
- Edge pulses:
  - rise_out[i] = 1 for exactly the one cycle in which level_out[i] has just changed 0->1; fall_out likewise for 1->0.
  - All edge outputs are registered alongside level_out, so a pulse and the new level appear together.
- sample_en=0: counters, levels and pulses hold/clear as follows.
  - Counters and levels hold.
  - rise_out and fall_out are 0, since the level cannot change.
- Latency, sample_en=1, counter at 0, input steady high: level_out and rise_out assert SYNC_STAGES+THRESH clk edges after the first edge that samples data_in=1. Falling latency from CNT_MAX is symmetric.
- Glitches shorter than the hysteresis band never toggle the level. Chatter inside the band holds the level.
- Channels are fully independent. Simultaneous edges on several channels all pulse in the same cycle; any_edge asserts once.
- Reset mid-filter clears all state. No pulse is generated by reset assertion or release.

Decomposition:
- Package debounce_pkg:
  - parameter-check function that validates the THRESH/CNT_MAX relation;
  - default constants DB_CNT_W, DB_CNT_MAX, DB_THRESH, DB_SYNC_STAGES.
- Sub-module debounce_channel:
  - one synchroniser, counter, level register and edge register;
  - instantiated CHANNELS times via generate;
  - the top adds only the any_edge reduction.

Test Plan (CHANNELS=2, CNT_W=3, CNT_MAX=7, THRESH=5, SYNC_STAGES=2, sample_en=1 unless stated):
1. Reset check: pulse rst mid-simulation with data_in=2'b11 steady -> all outputs 0 during reset. After release, level_out[0] rises exactly 7 edges later with a single rise_out pulse.
2. Clean rise/fall: ch0 from 0 to 1, hold 20 cycles, then to 0:
   - level_out[0]=1 and rise_out[0]=1 for one cycle, on the 7th edge after the first high sample;
   - fall_out[0] after counter 7->2, on the 7th edge after the first low sample.
3. Glitch rejection: ch1 high for 4 cycles then low -> counter peaks at 4 < THRESH, so level_out[1] stays 0 and no pulses.
4. Hysteresis hold: drive ch0 to level 1 (cnt=7), then alternate low/high every 2 cycles -> cnt oscillates within 5..7, level stays 1 with no fall_out.
5. Saturation: hold ch0 high 50 cycles -> cnt stays 7, no wrap, no extra rise_out. Hold low 50 cycles -> cnt stays 0.
6. Sample enable and simultaneity:
   - sample_en=1 every 4th clk -> rise latency = 2 + 5*4 edges (+/-3 for phase);
   - both channels rising together -> rise_out=2'b11 in one cycle, any_edge single-cycle high.
